// File: rtl/dfp_line_mem.sv
`default_nettype none
// ============================================================================
// Module   : dfp_line_mem
// Purpose  : Fixed-latency 256-bit cacheline memory behind the cache dfp port,
//            with a sticky flag for initiator protocol violations.
// Revision : 1.0
// ============================================================================
module dfp_line_mem #(
  parameter int LATENCY = 4,
  parameter int IDX_W   = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  dfp_addr,
  input  logic         dfp_read,
  input  logic         dfp_write,
  input  logic [255:0] dfp_wdata,
  output logic [255:0] dfp_rdata,
  output logic         dfp_resp,
  output logic         err
);

  localparam logic [7:0] c_lat_m1  = 8'(LATENCY - 1);
  localparam bit         c_lat_one = (LATENCY == 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [7:0]         r_cnt;
  logic               r_acc_rd;
  logic               r_acc_wr;
  logic [26:0]        r_addr_hi;
  logic [255:0]       r_wdata;
  logic [255:0]       r_mem [2**IDX_W];

  logic               w_idle;
  logic               w_accept;
  logic               w_to_resp;
  logic               w_is_wr;
  logic [IDX_W-1:0]   w_idx;
  logic [255:0]       w_wdata;
  logic               w_viol;
  logic               w_unused;

  assign w_unused = ^dfp_addr[4:0];

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = rst && w_idle && (dfp_read || dfp_write);
  assign w_to_resp = (w_accept && c_lat_one) ||
                     (rst && (r_state == S_WAIT) && (r_cnt == 8'd1));

  // With LATENCY==1 the RESP edge is the acceptance edge, so the live inputs
  // must be used instead of the not-yet-latched copies.
  assign w_is_wr = w_idle ? dfp_write : r_acc_wr;
  assign w_idx   = w_idle ? dfp_addr[5+IDX_W-1:5] : r_addr_hi[IDX_W-1:0];
  assign w_wdata = w_idle ? dfp_wdata : r_wdata;

  assign w_viol = (r_state == S_WAIT) &&
                  ((dfp_read != r_acc_rd) || (dfp_write != r_acc_wr) ||
                   (dfp_addr[31:5] != r_addr_hi));

  // Array is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_to_resp && w_is_wr) begin
      r_mem[w_idx] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= 8'd0;
      r_acc_rd  <= 1'b0;
      r_acc_wr  <= 1'b0;
      r_addr_hi <= 27'd0;
      r_wdata   <= '0;
      dfp_resp  <= 1'b0;
      dfp_rdata <= '0;
      err       <= 1'b0;
    end else begin
      dfp_resp  <= w_to_resp;
      dfp_rdata <= (w_to_resp && !w_is_wr) ? r_mem[w_idx] : '0;
      if ((w_accept && dfp_read && dfp_write) || w_viol) begin
        err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (dfp_read || dfp_write) begin
            r_acc_rd  <= dfp_read;
            r_acc_wr  <= dfp_write;
            r_addr_hi <= dfp_addr[31:5];
            r_wdata   <= dfp_wdata;
            r_cnt     <= c_lat_m1;
            r_state   <= c_lat_one ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dfp_line_mem.sv
`default_nettype none
// Bench for dfp_line_mem: three instances (LATENCY 4, 1, 8) checked every
// cycle against a transaction-scheduling model, plus literal expectations.
module tb_dfp_line_mem;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  addr_i  [3];
  logic         rd_i    [3];
  logic         wr_i    [3];
  logic [255:0] wd_i    [3];
  logic [255:0] rdata_o [3];
  logic         resp_o  [3];
  logic         err_o   [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dfp_line_mem #(
      .LATENCY(g == 0 ? 4 : (g == 1 ? 1 : 8)),
      .IDX_W  (6)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .dfp_addr (addr_i[g]),
      .dfp_read (rd_i[g]),
      .dfp_write(wr_i[g]),
      .dfp_wdata(wd_i[g]),
      .dfp_rdata(rdata_o[g]),
      .dfp_resp (resp_o[g]),
      .err      (err_o[g])
    );
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : ((k == 1) ? 1 : 8);
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: schedule-based, per instance ----------
  logic [255:0] mem   [3][64];
  bit           known [3][64];
  bit           pend  [3];
  bit           after [3];
  int           done_at [3];
  logic         a_rd [3];
  logic         a_wr [3];
  logic [26:0]  a_hi [3];
  logic [255:0] a_data [3];
  logic         m_resp  [3];
  logic [255:0] m_rdata [3];
  bit           m_known [3];
  logic         m_err   [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0; after[k] = 0; m_resp[k] = 0; m_rdata[k] = '0;
      m_known[k] = 1; m_err[k] = 0;
      addr_i[k] = '0; rd_i[k] = 0; wr_i[k] = 0; wd_i[k] = '0;
      for (int i = 0; i < 64; i++) known[k][i] = 0;
    end
  end

  task automatic complete(input int k);
    int idx;
    idx = int'(a_hi[k][5:0]);
    m_resp[k] = 1'b1;
    if (a_wr[k]) begin
      mem[k][idx]   = a_data[k];
      known[k][idx] = 1;
    end else begin
      m_rdata[k] = mem[k][idx];
      m_known[k] = known[k][idx];
    end
    pend[k]  = 0;
    after[k] = 1;
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 3; k++) begin
      m_resp[k] = 0; m_rdata[k] = '0; m_known[k] = 1;
      if (!rst) begin
        pend[k] = 0; after[k] = 0; m_err[k] = 0;
      end else if (pend[k]) begin
        if (rd_i[k] !== a_rd[k] || wr_i[k] !== a_wr[k] || addr_i[k][31:5] !== a_hi[k])
          m_err[k] = 1;
        if (cyc == done_at[k]) complete(k);
      end else if (after[k]) begin
        after[k] = 0;
      end else if (rd_i[k] || wr_i[k]) begin
        a_rd[k] = rd_i[k]; a_wr[k] = wr_i[k];
        a_hi[k] = addr_i[k][31:5]; a_data[k] = wd_i[k];
        if (rd_i[k] && wr_i[k]) m_err[k] = 1;
        done_at[k] = cyc + lat_of(k) - 1;
        if (lat_of(k) == 1) complete(k);
        else pend[k] = 1;
      end
    end
  end

  always @(negedge rst) begin
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0; after[k] = 0; m_err[k] = 0;
      m_resp[k] = 0; m_rdata[k] = '0; m_known[k] = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_resp[%0d]", k), {255'd0, resp_o[k]}, {255'd0, m_resp[k]});
        chk($sformatf("model_err[%0d]", k), {255'd0, err_o[k]}, {255'd0, m_err[k]});
        if (!(m_resp[k] && !m_known[k]))
          chk($sformatf("model_rdata[%0d]", k), rdata_o[k], m_rdata[k]);
      end
    end
  end

  // ---------------- driver ---------------------------------------------------
  task automatic txn(input int k, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [255:0] d, input bit glitch,
                     output logic [255:0] rdat, output int lat, output int rc);
    int c0;
    bit got;
    got = 0; lat = -1; rc = -1; rdat = '0;
    @(posedge clk); #1;
    rd_i[k] = rd; wr_i[k] = wr; addr_i[k] = a; wd_i[k] = d;
    c0 = cyc;
    for (int i = 0; i < lat_of(k) + 4 && !got; i++) begin
      @(posedge clk); #1;
      if (glitch && i == 1) addr_i[k] = a ^ 32'h0000_0100;
      if (resp_o[k]) begin
        got = 1; rdat = rdata_o[k]; lat = cyc - c0; rc = cyc;
      end
    end
    chk($sformatf("resp_seen[%0d]", k), {255'd0, got}, 256'd1);
    rd_i[k] = 0; wr_i[k] = 0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 0;
    repeat (n) @(posedge clk);
    #1 rst = 1;
  endtask

  logic [255:0] rdat;
  int lat, rc, rc1, nresp;
  localparam logic [255:0] c_beef = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] c_v5   = {8{32'h5555_A0A0}};
  localparam logic [255:0] c_prev = {8{32'hC0FF_EE02}};
  localparam logic [255:0] c_both = {8{32'h0B07_4111}};

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_en = 1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_resp", {255'd0, resp_o[k]}, 256'd0);
      chk("reset_err", {255'd0, err_o[k]}, 256'd0);
      chk("reset_rdata", rdata_o[k], 256'd0);
    end
    rst = 1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("idle_resp", {255'd0, resp_o[0]}, 256'd0);
      chk("idle_err", {255'd0, err_o[0]}, 256'd0);
    end

    // LATENCY=4 write then read
    txn(0, 0, 1, 32'h0000_0040, c_beef, 0, rdat, lat, rc);
    chk("wr_lat4", 256'(lat), 256'd4);
    txn(0, 1, 0, 32'h0000_0040, '0, 0, rdat, lat, rc);
    chk("rd_lat4", 256'(lat), 256'd4);
    chk("rd_beef", rdat, c_beef);

    // offset ignored and upper bits alias: 0x83F maps to the same idx 1 as 0x20
    txn(0, 0, 1, 32'h0000_0020, c_v5, 0, rdat, lat, rc);
    txn(0, 1, 0, 32'h0000_083F, '0, 0, rdat, lat, rc);
    chk("alias_rd", rdat, c_v5);

    // LATENCY=1 writeback followed by allocate
    txn(1, 0, 1, 32'h0000_00A0, c_v5, 0, rdat, lat, rc);
    txn(1, 0, 1, 32'h0000_0060, 256'h1, 0, rdat, lat, rc1);
    chk("wb_lat1", 256'(lat), 256'd1);
    txn(1, 1, 0, 32'h0000_00A0, '0, 0, rdat, lat, rc);
    chk("alloc_spacing", 256'(rc - rc1), 256'd2);
    chk("alloc_data", rdat, c_v5);
    txn(1, 1, 0, 32'h0000_0060, '0, 0, rdat, lat, rc);
    chk("idx3_data", rdat, 256'h1);

    // both read and write: write wins, err sticks
    txn(0, 1, 1, 32'h0000_0100, c_both, 0, rdat, lat, rc);
    chk("both_err", {255'd0, err_o[0]}, 256'd1);
    txn(0, 1, 0, 32'h0000_0100, '0, 0, rdat, lat, rc);
    chk("both_committed", rdat, c_both);
    chk("err_sticky", {255'd0, err_o[0]}, 256'd1);
    do_reset(2);
    chk("err_cleared", {255'd0, err_o[0]}, 256'd0);

    // address change mid-WAIT: err sets, response stays on schedule
    txn(0, 0, 1, 32'h0000_0180, c_beef, 1, rdat, lat, rc);
    chk("glitch_lat", 256'(lat), 256'd4);
    chk("glitch_err", {255'd0, err_o[0]}, 256'd1);
    repeat (5) @(posedge clk);
    do_reset(1);

    // reset mid-WAIT on LATENCY=8 drops the write
    txn(2, 0, 1, 32'h0000_0040, c_prev, 0, rdat, lat, rc);
    chk("lat8", 256'(lat), 256'd8);
    @(posedge clk); #1;
    wr_i[2] = 1; addr_i[2] = 32'h0000_0040; wd_i[2] = 256'hF;
    nresp = 0;
    repeat (2) begin @(posedge clk); #1; if (resp_o[2]) nresp++; end
    rst = 0; wr_i[2] = 0;
    repeat (12) begin @(posedge clk); #1; if (resp_o[2]) nresp++; end
    rst = 1;
    chk("rst_noresp", 256'(nresp), 256'd0);
    txn(2, 1, 0, 32'h0000_0040, '0, 0, rdat, lat, rc);
    chk("rst_prior_kept", rdat, c_prev);

    // randomized traffic, all instances
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        logic [31:0]  a;
        logic [255:0] d;
        logic         w;
        w = 1'($urandom_range(0, 1));
        a = $urandom;
        a[10:5] = 6'($urandom_range(0, 7));
        for (int j = 0; j < 8; j++) d[j*32 +: 32] = $urandom;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        txn(k, !w, w, a, d, 0, rdat, lat, rc);
        chk("rand_lat", 256'(lat), 256'(lat_of(k)));
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
